cnn_conv_sequencer: RTL and testbench



---
 rtl/cnn_conv_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_cnn_conv_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_conv_sequencer.sv
// Convolution pass sequencer: streams raster-order pixel addresses with KxK
// window flags, flushes the datapath pipeline, and keeps sticky run status.
module cnn_conv_sequencer #(
  parameter int MAX_W     = 64,
  parameter int MAX_K     = 7,
  parameter int ADDR_W    = 12,
  parameter int DRAIN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       cfg_control,
  input  logic [31:0]       cfg_width,
  input  logic [31:0]       cfg_ksize,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_row,
  output logic [7:0]        pix_col,
  output logic              win_valid,
  output logic              busy,
  output logic              done_pulse,
  output logic [31:0]       status
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

  logic [1:0]         state_q, state_d;
  logic               start_q;
  logic [7:0]         w_q, w_d;
  logic [7:0]         k_q, k_d;
  logic [7:0]         row_q, row_d;
  logic [7:0]         col_q, col_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [15:0]        out_count_q, out_count_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               aborted_q, aborted_d;
  logic               done_pulse_q, done_pulse_d;

  logic start_re;
  logic abort_req;
  logic cfg_legal;
  logic in_run;
  logic beat;
  logic col_last;
  logic row_last;
  logic unused_ctrl;

  assign start_re  = cfg_control[0] & ~start_q;
  assign abort_req = cfg_control[1];
  assign unused_ctrl = ^cfg_control[31:2];

  // Full-width compares so any stray upper bit makes the configuration illegal.
  assign cfg_legal = (cfg_width >= 32'd1) && (cfg_width <= 32'(MAX_W)) &&
                     (cfg_ksize >= 32'd1) && (cfg_ksize <= 32'(MAX_K)) &&
                     (cfg_ksize <= cfg_width);

  assign in_run   = (state_q == ST_RUN);
  assign beat     = in_run & pix_ready;
  assign col_last = (col_q == w_q - 8'd1);
  assign row_last = (row_q == w_q - 8'd1);

  assign pix_valid  = in_run;
  assign pix_addr   = addr_q;
  assign pix_row    = row_q;
  assign pix_col    = col_q;
  assign win_valid  = in_run && (row_q >= k_q - 8'd1) && (col_q >= k_q - 8'd1);
  assign busy       = (state_q != ST_IDLE);
  assign done_pulse = done_pulse_q;
  assign status     = {out_count_q, 12'd0, aborted_q, cfg_err_q, done_q, busy};

  always_comb begin
    // NOTE: every next-state signal starts from its register value so no path
    // through the case statement leaves a latch behind.
    state_d      = state_q;
    w_d          = w_q;
    k_d          = k_q;
    row_d        = row_q;
    col_d        = col_q;
    addr_d       = addr_q;
    out_count_d  = out_count_q;
    drain_d      = drain_q;
    done_d       = done_q;
    cfg_err_d    = cfg_err_q;
    aborted_d    = aborted_q;
    done_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_re) begin
          w_d         = cfg_width[7:0];
          k_d         = cfg_ksize[7:0];
          done_d      = 1'b0;
          aborted_d   = 1'b0;
          out_count_d = 16'd0;
          row_d       = 8'd0;
          col_d       = 8'd0;
          addr_d      = '0;
          if (cfg_legal) begin
            cfg_err_d = 1'b0;
            state_d   = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (abort_req) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
          row_d     = 8'd0;
          col_d     = 8'd0;
          addr_d    = '0;
        end else if (beat) begin
          out_count_d = out_count_q + {15'd0, win_valid};
          if (col_last) begin
            col_d = 8'd0;
            if (row_last) begin
              state_d = ST_DRAIN;
              drain_d = DRAIN_W'(DRAIN_CYC);
              row_d   = 8'd0;
              addr_d  = '0;
            end else begin
              row_d  = row_q + 8'd1;
              addr_d = addr_q + 1'b1;
            end
          end else begin
            col_d  = col_q + 8'd1;
            addr_d = addr_q + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (abort_req) begin
          state_d   = ST_IDLE;
          aborted_d = 1'b1;
        end else if (drain_q == DRAIN_W'(1)) begin
          // Counter hits zero on the transition, so the pulse lands in IDLE.
          state_d      = ST_IDLE;
          drain_d      = '0;
          done_d       = 1'b1;
          done_pulse_d = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      w_q          <= 8'd0;
      k_q          <= 8'd0;
      row_q        <= 8'd0;
      col_q        <= 8'd0;
      addr_q       <= '0;
      out_count_q  <= 16'd0;
      drain_q      <= '0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      aborted_q    <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= cfg_control[0];
      w_q          <= w_d;
      k_q          <= k_d;
      row_q        <= row_d;
      col_q        <= col_d;
      addr_q       <= addr_d;
      out_count_q  <= out_count_d;
      drain_q      <= drain_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      aborted_q    <= aborted_d;
      done_pulse_q <= done_pulse_d;
    end
  end

endmodule

// File: tb/tb_cnn_conv_sequencer.sv
// Scoreboard bench for cnn_conv_sequencer: expected beats are queued at start
// and popped as the DUT presents them; inputs change and outputs are read on negedge.
module tb_cnn_conv_sequencer;

  localparam int MAX_W     = 64;
  localparam int MAX_K     = 7;
  localparam int ADDR_W    = 12;
  localparam int DRAIN_CYC = 4;

  localparam logic [31:0] BAD_W [6] = '{32'd4, 32'd0, 32'h0001_0004, 32'd65, 32'd8, 32'd64};
  localparam logic [31:0] BAD_K [6] = '{32'd5, 32'd1, 32'd3,         32'd3,  32'd0, 32'd8};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       cfg_control;
  logic [31:0]       cfg_width;
  logic [31:0]       cfg_ksize;
  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W-1:0] pix_addr;
  logic [7:0]        pix_row;
  logic [7:0]        pix_col;
  logic              win_valid;
  logic              busy;
  logic              done_pulse;
  logic [31:0]       status;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        row;
    logic [7:0]        col;
    logic              win;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_mis = 0;

  always #5 clk = ~clk;

  cnn_conv_sequencer #(
    .MAX_W    (MAX_W),
    .MAX_K    (MAX_K),
    .ADDR_W   (ADDR_W),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_control(cfg_control),
    .cfg_width  (cfg_width),
    .cfg_ksize  (cfg_ksize),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_addr   (pix_addr),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .win_valid  (win_valid),
    .busy       (busy),
    .done_pulse (done_pulse),
    .status     (status)
  );

  // mode: 0 always ready, 1 ready toggling 1-0-1, 2 random ready.
  // abort_after >= 0 raises abort once that many beats have been accepted.
  task automatic drive_run(input int w, input int k, input int mode, input int abort_after,
                           input logic [31:0] start_word, input bit hold_start);
    int    beats, last_cyc, done_cyc, exp_cnt, win_total;
    bit    rdy, abort_sent;
    beat_t e;
    beats = 0; last_cyc = -1; done_cyc = -1; exp_cnt = 0; abort_sent = 1'b0;
    win_total = (w - k + 1) * (w - k + 1);
    for (int r = 0; r < w; r++)
      for (int c = 0; c < w; c++)
        exp_q.push_back('{addr: ADDR_W'(r * w + c), row: 8'(r), col: 8'(c),
                          win: (r >= k - 1) && (c >= k - 1)});
    @(negedge clk);
    cfg_width   = 32'(w);
    cfg_ksize   = 32'(k);
    cfg_control = start_word;
    for (int cyc = 0; cyc < w * w * 3 + 40; cyc++) begin
      @(negedge clk);
      cfg_control[1] = 1'b0;
      if (!hold_start) cfg_control[0] = 1'b0;
      if (done_pulse) begin done_cyc = cyc; break; end
      if (abort_sent) break;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      pix_ready = rdy;
      if (pix_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_mis++;
          $display("FAIL extra_beat: got addr=%0d row=%0d col=%0d, required no beat", pix_addr, pix_row, pix_col);
        end else begin
          e = exp_q[0];
          if ({pix_addr, pix_row, pix_col, win_valid} !== e) begin
            n_mis++;
            $display("FAIL beat W=%0d K=%0d: got addr=%0d row=%0d col=%0d win=%0b, required addr=%0d row=%0d col=%0d win=%0b",
                     w, k, pix_addr, pix_row, pix_col, win_valid, e.addr, e.row, e.col, e.win);
          end
          if (abort_after >= 0 && beats == abort_after) begin
            cfg_control[1] = 1'b1;
            abort_sent = 1'b1;
          end else if (rdy) begin
            void'(exp_q.pop_front());
            beats++;
            exp_cnt += int'(e.win);
            last_cyc = cyc;
          end
        end
      end
    end

    if (abort_after >= 0) begin
      n_cmp++;
      if (!abort_sent || pix_valid !== 1'b0 || busy !== 1'b0 || status !== {16'(exp_cnt), 16'h0008}) begin
        n_mis++;
        $display("FAIL abort_state: got sent=%0b valid=%0b busy=%0b status=%h, required valid=0 busy=0 status=%h",
                 abort_sent, pix_valid, busy, status, {16'(exp_cnt), 16'h0008});
      end
      repeat (DRAIN_CYC + 3) begin
        @(negedge clk);
        n_cmp++;
        if (done_pulse !== 1'b0 || pix_valid !== 1'b0) begin
          n_mis++;
          $display("FAIL abort_quiet: got done_pulse=%0b valid=%0b, required 0/0", done_pulse, pix_valid);
        end
      end
    end else begin
      n_cmp++;
      if (done_cyc < 0 || done_cyc - last_cyc != DRAIN_CYC + 1) begin
        n_mis++;
        $display("FAIL done_latency W=%0d K=%0d: got %0d cycles after last beat (done_cyc=%0d), required %0d",
                 w, k, done_cyc - last_cyc, done_cyc, DRAIN_CYC + 1);
      end
      n_cmp++;
      if (status !== {16'(win_total), 16'h0002}) begin
        n_mis++;
        $display("FAIL done_status W=%0d K=%0d: got %h, required %h", w, k, status, {16'(win_total), 16'h0002});
      end
      n_cmp++;
      if ({pix_addr, pix_row, pix_col, pix_valid, busy} !== '0) begin
        n_mis++;
        $display("FAIL idle_position: got addr=%0d row=%0d col=%0d valid=%0b busy=%0b, required all 0",
                 pix_addr, pix_row, pix_col, pix_valid, busy);
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_mis++;
        $display("FAIL beat_count W=%0d K=%0d: got %0d beats, required %0d", w, k, beats, w * w);
      end
      @(negedge clk);
      n_cmp++;
      if (done_pulse !== 1'b0) begin
        n_mis++;
        $display("FAIL pulse_width: got done_pulse=1 on second cycle, required 0");
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_control = '0; cfg_width = '0; cfg_ksize = '0; pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({pix_valid, pix_addr, pix_row, pix_col, win_valid, busy, done_pulse} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got valid=%0b addr=%0d row=%0d col=%0d win=%0b busy=%0b pulse=%0b, required all 0",
               pix_valid, pix_addr, pix_row, pix_col, win_valid, busy, done_pulse);
    end
    n_cmp++;
    if (status !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_status: got %h, required 00000000", status);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    drive_run(4, 3, 0, -1, 32'h1, 1'b0);
  endtask

  task automatic test_stall();
    drive_run(4, 3, 1, -1, 32'h1, 1'b0);
  endtask

  task automatic test_illegal_cfg();
    bit saw;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cfg_width = BAD_W[i]; cfg_ksize = BAD_K[i]; cfg_control = 32'h1; pix_ready = 1'b1;
      @(negedge clk);
      cfg_control = 32'h0;
      saw = (pix_valid !== 1'b0);
      repeat (4) begin
        @(negedge clk);
        if (pix_valid !== 1'b0 || busy !== 1'b0) saw = 1'b1;
      end
      n_cmp++;
      if (saw || status !== 32'h0000_0004) begin
        n_mis++;
        $display("FAIL illegal_cfg W=%h K=%h: got status=%h saw_valid=%0b, required status=00000004 no beats",
                 BAD_W[i], BAD_K[i], status, saw);
      end
    end
    drive_run(4, 3, 0, -1, 32'h1, 1'b0);
  endtask

  task automatic test_abort();
    drive_run(8, 3, 0, 20, 32'h1, 1'b0);
    drive_run(8, 3, 0, -1, 32'h1, 1'b0);
  endtask

  task automatic test_corners();
    drive_run(1, 1, 0, -1, 32'h1, 1'b0);
    drive_run(MAX_W, MAX_K, 0, -1, 32'h1, 1'b0);
  endtask

  task automatic test_hold_start();
    bit saw;
    drive_run(4, 3, 0, -1, 32'h1, 1'b1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (pix_valid !== 1'b0 || done_pulse !== 1'b0) saw = 1'b1;
    end
    n_cmp++;
    if (saw) begin
      n_mis++;
      $display("FAIL hold_start: got a second run while start held high, required exactly one run");
    end
    cfg_control = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    bit saw;
    @(negedge clk);
    cfg_width = 32'd8; cfg_ksize = 32'd3; cfg_control = 32'h1; pix_ready = 1'b1;
    @(negedge clk);
    cfg_control = 32'h0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (pix_valid !== 1'b1 || pix_row !== 8'd1) begin
      n_mis++;
      $display("FAIL run_before_reset: got valid=%0b row=%0d, required valid=1 row=1", pix_valid, pix_row);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pix_valid, pix_addr, pix_row, pix_col, win_valid, busy, done_pulse, status} !== '0) begin
      n_mis++;
      $display("FAIL reset_midrun: got valid=%0b addr=%0d row=%0d col=%0d busy=%0b status=%h, required all 0",
               pix_valid, pix_addr, pix_row, pix_col, busy, status);
    end
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (DRAIN_CYC + 20) begin
      @(negedge clk);
      if (done_pulse !== 1'b0 || pix_valid !== 1'b0) saw = 1'b1;
    end
    n_cmp++;
    if (saw) begin
      n_mis++;
      $display("FAIL after_reset: got done_pulse or pix_valid after reset, required none");
    end
  endtask

  task automatic test_back_to_back();
    drive_run(5, 2, 2, -1, 32'h3, 1'b0);
    drive_run(6, 6, 2, -1, 32'h1, 1'b0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_illegal_cfg();
    test_abort();
    test_corners();
    test_hold_start();
    test_reset_midrun();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
